// File: rtl/note_seq_pkg.sv
// note_seq_pkg: sequencer state encoding and note word field layout.
package note_seq_pkg;
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, GAP, PAUSED, DONE} state_t;
    localparam int DUR_MSB = 11;
    localparam int DUR_LSB = 8;
    localparam int TONE_MSB = 7;
    localparam int TONE_LSB = 0;
    localparam logic [11:0] END_WORD = 12'h000;
endpackage

// File: rtl/tick_gen.sv
// tick_gen: enable-gated modulo-DIV counter that pulses tick on the cycle it wraps.
module tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int W = $clog2(DIV);
    logic [W-1:0] cnt_q, cnt_d;
    assign tick = en && !clr && (cnt_q == W'(DIV - 1));
    always_comb cnt_d = (clr || tick) ? '0 : en ? cnt_q + W'(1) : cnt_q;
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) cnt_q <= '0;
        else cnt_q <= cnt_d;
endmodule

// File: rtl/note_sequencer.sv
// note_sequencer: beat-timed note ROM player with pause/stop and end-of-song detection.
// Define NOTE_SEQ_LOOP_EN to restart from address 0 after each song end instead of idling.
module note_sequencer
    import note_seq_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 12,
    parameter int TICK_DIV = 6_250_000,
    parameter int GAP_CYC = 0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              play,
    input  logic              pause,
    input  logic              stop,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [7:0]        tone_code,
    output logic              tone_valid,
    output logic              busy,
    output logic              song_done
);
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    state_t state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0] tone_q, tone_d;
    logic [3:0] dur_q, dur_d, dur_in;
    logic [GW-1:0] gap_q, gap_d;
    logic valid_q, valid_d, busy_q, busy_d, done_q, done_d;
    logic tick, note_end, last_addr;

    // The beat counter only runs in PLAY, holds in PAUSED and restarts for every note.
    tick_gen #(.DIV(TICK_DIV)) u_tick (
        .clk(clk),
        .rstn(rstn),
        .en(state_q == PLAY),
        .clr(stop || ((state_q != PLAY) && (state_q != PAUSED))),
        .tick(tick)
    );

    assign dur_in = rom_data[DUR_MSB:DUR_LSB];
    assign note_end = tick && (dur_q == 4'd1);
    assign last_addr = &addr_q;

    always_comb begin
        state_d = state_q;
        addr_d = addr_q;
        tone_d = tone_q;
        dur_d = tick ? dur_q - 4'd1 : dur_q;
        gap_d = gap_q;
        if (stop) begin
            state_d = IDLE;
            addr_d = '0;
            dur_d = '0;
        end else begin
            case (state_q)
                IDLE: state_d = play ? FETCH : IDLE;
                FETCH: state_d = LOAD;
                LOAD: begin
                    if (rom_data == DATA_W'(END_WORD)) begin
                        state_d = DONE;
                    end else begin
                        state_d = PLAY;
                        tone_d = rom_data[TONE_MSB:TONE_LSB];
                        dur_d = (dur_in == 4'd0) ? 4'd1 : dur_in;
                    end
                end
                // Finishing a note wins over pause; the top address ends the song rather than wrapping.
                PLAY: begin
                    if (note_end) begin
                        state_d = last_addr ? DONE : (GAP_CYC > 0) ? GAP : FETCH;
                        addr_d = last_addr ? addr_q : addr_q + ADDR_W'(1);
                        gap_d = '0;
                    end else if (pause) begin
                        state_d = PAUSED;
                    end
                end
                GAP: begin
                    gap_d = gap_q + GW'(1);
                    state_d = (gap_q == GW'(GAP_CYC - 1)) ? FETCH : GAP;
                end
                PAUSED: state_d = (play && !pause) ? PLAY : PAUSED;
                DONE: begin
                    addr_d = '0;
`ifdef NOTE_SEQ_LOOP_EN
                    state_d = FETCH;
`else
                    state_d = IDLE;
`endif
                end
                default: state_d = IDLE;
            endcase
        end
        if (state_d == IDLE) tone_d = '0;
        valid_d = (state_d == PLAY);
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            addr_q <= '0;
            tone_q <= '0;
            dur_q <= '0;
            gap_q <= '0;
            valid_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q <= addr_d;
            tone_q <= tone_d;
            dur_q <= dur_d;
            gap_q <= gap_d;
            valid_q <= valid_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign rom_addr = addr_q;
    assign tone_code = tone_q;
    assign tone_valid = valid_q;
    assign busy = busy_q;
    assign song_done = done_q;
endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Plays a song stored in the note ROM. Steps the ROM address, decodes each 12-bit note word, and drives a tone code to the tone divider for the note's duration.
- Sits between the user controls (play/pause/stop) and the note ROM plus tone generator. It replaces free-running address stepping with beat-timed sequencing and end-of-song detection.

Parameters:
- ADDR_W, 9, ROM address width.
- DATA_W, 12, ROM word width. Fixed format: [11:8] duration in ticks, [7:0] tone code.
- TICK_DIV, 6_250_000, clk cycles per duration tick (must be >= 2).
- GAP_CYC, 0, silent clk cycles between consecutive notes. 0 means no gap state.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- play  in  1  level; start from IDLE or resume from PAUSED
- pause  in  1  level; freeze playback while in PLAY
- stop  in  1  level; abort to IDLE, address to 0
- rom_addr  out  ADDR_W  note ROM address
- rom_data  in  DATA_W  ROM word, registered ROM, valid 1 cycle after rom_addr
- tone_code  out  8  current tone, 0 = rest
- tone_valid  out  1  high while a note is sounding (PLAY, not paused)
- busy  out  1  high in every state except IDLE
- song_done  out  1  one-cycle pulse on end of song

Behaviour:
- Reset: all outputs 0, state IDLE, tick and duration counters 0.
- States:
  - IDLE -> FETCH on play. rom_addr already 0.
  - FETCH: one cycle, ROM read in flight.
  - LOAD: latches rom_data.
    - Word == 0 is the end marker -> DONE.
    - Otherwise tone_code <= data[7:0]; dur_cnt <= data[11:8], with duration 0 treated as 1; go to PLAY.
  - PLAY: tick counter counts 0..TICK_DIV-1. Each wrap decrements dur_cnt. At the wrap where dur_cnt==1: rom_addr+1, then go to GAP if GAP_CYC>0, else FETCH.
  - GAP: tone_valid=0 for GAP_CYC cycles -> FETCH.
  - PAUSED: entered from PLAY when pause=1. tick/dur counters frozen, tone_valid=0. Exits to PLAY when play=1 and pause=0.
  - DONE: one cycle. Pulses song_done, rom_addr<=0 -> IDLE.
- Latency: play sampled at edge N -> FETCH at N+1, LOAD at N+2, tone_valid=1 from N+3. A note lasts exactly duration×TICK_DIV cycles of PLAY.
- Address wrap: if the word at the maximum address (2^ADDR_W-1) finishes without an end marker, treat it as end of song (DONE). rom_addr never silently wraps.
- Priority per cycle: stop > pause > play.
  - stop in any state -> IDLE next cycle, rom_addr=0, tone outputs cleared, no song_done.
  - pause outside PLAY is ignored.
  - play while busy and not PAUSED is ignored.
- tone_code stays at its last value in PAUSED and GAP. It clears to 0 in IDLE.
- Reset mid-note: immediate return to the reset values; no pulse.

Optional Feature:
- Macro: NOTE_SEQ_LOOP_EN.
- Defined: the end marker or address wrap goes through DONE (song_done still pulses) and then to FETCH at address 0 instead of IDLE. Playback loops until stop.
- Undefined: DONE -> IDLE as specified above.

Decomposition:
- Package note_seq_pkg:
  - state enum: IDLE, FETCH, LOAD, PLAY, GAP, PAUSED, DONE.
  - field constants: DUR_MSB=11, DUR_LSB=8, TONE_MSB=7, TONE_LSB=0.
  - END_WORD=0.
- Sub-module tick_gen: enable-gated counter to TICK_DIV-1 with clear input and one-cycle tick output. Reused by the tone divider.

Test Plan (TICK_DIV=4, GAP_CYC=0 unless stated):
- ROM {0x203, 0x105, 0x000}, pulse play -> tone_valid high 3 cycles after play. tone_code=0x03 for 8 cycles, then 0x05 for 4 cycles. song_done pulses once, then busy=0 and rom_addr=0.
- Word 0x00A (duration 0) -> tone 0x0A plays for 4 cycles.
- pause for 5 cycles mid-note of 0x303 -> tone_valid low during the pause. Total PLAY time is still 12 cycles after resume with play.
- stop asserted together with play and pause during PLAY -> IDLE next cycle, rom_addr=0, song_done stays 0.
- GAP_CYC=2, ROM {0x101, 0x102, 0x000} -> 2-cycle tone_valid low gap between notes, with tone_code held at 0x01.
- NOTE_SEQ_LOOP_EN defined, ROM {0x101, 0x000} -> song_done pulses every loop, and tone 0x01 repeats until stop.
